lcd_fb_sched: RTL and testbench
===============================

Name: lcd_fb_sched

Overview:
- Controller and arbiter for the LCD frame buffer.
- Shares one single-port synchronous RAM between two requesters: the PPU pixel writer and the scanout reader.
- Manages the two-bank double-buffer: write pointer, bank swap, and read-bank selection.
- Sits between the PPU pixel stream and the frame-buffer RAM, in the same clock domain as the PPU.

Parameters:
- ADDR_W, 15, pixel index width per bank.
- FRAME_PIX, 23040, pixels per frame (160x144).
- RD_THRESH, 9600, minimum write progress (160x60) needed to scan out the in-progress bank.
- FIFO_DEPTH, 4, write FIFO entries; must be a power of two, minimum 2.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- lcd_on  in  1  LCDC enable.
- mode  in  2  PPU STAT mode; 2'd1 = vblank.
- double_buffer  in  1  enables tear-free bank selection.
- pix_wr  in  1  pixel-valid strobe.
- pix_data  in  15  pixel value.
- rd_frame_start  in  1  one-cycle pulse from scanout at the start of the visible frame.
- rd_req  in  1  scanout requests the next pixel.
- rd_gnt  out  1  read accepted this cycle.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  15  read pixel.
- ram_addr  out  ADDR_W+1  {bank, index}.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  15  RAM write data.
- ram_rdata  in  15  RAM read data, registered output, 1-cycle latency.
- wr_bank  out  1  current write bank.
- rd_bank  out  1  current read bank.
- frame_ovf  out  1  sticky: a pixel arrived after FRAME_PIX pixels in one frame.

Behaviour:
- Reset values: all outputs 0; wr_ptr, rd_ptr = 0; FIFO empty; lcd_off_q = 1.
- lcd_off = !lcd_on || mode==2'd1, registered as lcd_off_q.
- Frame boundary: on the cycle lcd_off_q rises, wr_ptr <= 0 and wr_bank toggles.
- Write acceptance:
  - pix_wr is ignored while lcd_off_q=1.
  - Otherwise, if wr_ptr < FRAME_PIX: push {wr_bank, wr_ptr, pix_data} into the FIFO and wr_ptr++.
  - Otherwise drop the pixel and set frame_ovf. frame_ovf is cleared only by reset.
- Bank and address travel with each FIFO entry. Entries queued before a swap still land in the old bank.
- If a swap and an accepted pix_wr occur in the same cycle, the pixel belongs to the new frame: index 0 of the new bank. wr_ptr becomes 1.
- Arbitration, evaluated each cycle:
  - FIFO full: write wins; rd_gnt=0.
  - Else rd_req: read wins; rd_gnt=1.
  - Else FIFO non-empty: write.
  - Else idle (ram_we=0).
- Writes are combinational from the FIFO head: ram_we=1, ram_addr = entry address, ram_wdata = entry data, pop.
- Push and pop in the same cycle are legal, including when the FIFO is full, because full forces a pop. The FIFO therefore never overflows.
- Read path:
  - On a grant, ram_addr = {rd_bank, rd_ptr}; rd_ptr saturates at FRAME_PIX-1.
  - rd_valid=1 exactly one cycle after rd_gnt, with rd_data = ram_rdata.
- rd_frame_start:
  - rd_ptr <= 0.
  - rd_bank <= wr_bank if (!double_buffer || wr_ptr >= RD_THRESH), else ~wr_bank.
  - If rd_req is asserted in the same cycle, the grant uses the new bank at index 0.
- rd_frame_start in the same cycle as a swap: the selection uses the pre-swap wr_bank and wr_ptr values.
- Asynchronous reset mid-frame: the FIFO is flushed and in-flight writes are lost. rd_valid is 0 on the first cycle after release.

Decomposition:
- Package lcd_pkg holds:
  - LCD_W=160, LCD_H=144, FRAME_PIX.
  - The fifo entry struct {bank, idx[ADDR_W-1:0], data[14:0]}.
  - The mode encodings MODE_HBL/VBL/OAM/XFER.
- Sub-module lcd_fb_wfifo: a synchronous FIFO with full/empty flags and simultaneous push/pop; reset is async active-high.
- Arbitration, pointers and bank logic stay in the top module.

Test Plan:
- Write-only: lcd_on=1, mode=3, 5 consecutive pix_wr (data 1..5), rd_req=0 → ram_we on 5 cycles, addresses {0,0}..{0,4}, data 1..5; FIFO ends empty.
- Read priority: FIFO holding 2 entries, rd_req held for 3 cycles → rd_gnt=1 for 3 cycles and rd_valid the cycle after each grant. Writes drain afterwards.
- Full override: fill the FIFO to 4 entries with rd_req=1 and pix_wr=1 every cycle → rd_gnt=0 while full, a write issued each such cycle, no pixel lost, frame_ovf=0.
- Bank swap: write 100 pixels, then mode→1 → wr_bank 0→1 and wr_ptr=0. The next pixel after mode returns to 3 is written to {1,0}.
- Read-bank select: double_buffer=1 with wr_ptr=9599 at rd_frame_start → rd_bank=~wr_bank. With wr_ptr=9600 → rd_bank=wr_bank. double_buffer=0 → rd_bank=wr_bank.
- Overflow: write 23041 pixels in one frame → the last pixel is dropped, no RAM write at index 23040, frame_ovf=1 until reset.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants and types for the LCD frame-buffer scheduler
package lcd_pkg;

  localparam int LCD_W     = 160;
  localparam int LCD_H     = 144;
  localparam int FRAME_PIX = LCD_W * LCD_H;
  localparam int ADDR_W    = 15;
  localparam int PIX_W     = 15;

  typedef enum logic [1:0] {
    MODE_HBL  = 2'd0,
    MODE_VBL  = 2'd1,
    MODE_OAM  = 2'd2,
    MODE_XFER = 2'd3
  } lcd_mode_e;

  // Bank and index travel with the pixel so a swap never redirects queued writes.
  typedef struct packed {
    logic              bank;
    logic [ADDR_W-1:0] idx;
    logic [PIX_W-1:0]  data;
  } fb_entry_t;

endpackage

// File: rtl/lcd_fb_wfifo.sv
// rtl/lcd_fb_wfifo.sv - pixel write FIFO with simultaneous push/pop and show-ahead head
module lcd_fb_wfifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_idx_q, rd_idx_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk_sys) begin
    if (push_i) mem_q[wr_idx_q] <= push_data_i;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_idx_q <= wr_idx_q + 1'b1;
      if (pop_i)  rd_idx_q <= rd_idx_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rd_idx_q];
  assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/lcd_fb_sched.sv
// rtl/lcd_fb_sched.sv - frame-buffer RAM arbiter between PPU writes and scanout reads
// with two-bank double buffering.
module lcd_fb_sched #(
  parameter int ADDR_W     = 15,
  parameter int FRAME_PIX  = 23040,
  parameter int RD_THRESH  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              lcd_on,
  input  logic [1:0]        mode,
  input  logic              double_buffer,
  input  logic              pix_wr,
  input  logic [14:0]       pix_data,
  input  logic              rd_frame_start,
  input  logic              rd_req,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [14:0]       rd_data,
  output logic [ADDR_W:0]   ram_addr,
  output logic              ram_we,
  output logic [14:0]       ram_wdata,
  input  logic [14:0]       ram_rdata,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              frame_ovf
);
  import lcd_pkg::*;

  localparam logic [ADDR_W-1:0] PTR_END  = ADDR_W'(FRAME_PIX);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(FRAME_PIX - 1);
  localparam logic [ADDR_W-1:0] PTR_THR  = ADDR_W'(RD_THRESH);

  logic              lcd_off, lcd_off_q, swap, accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, rd_sel;
  logic              frame_ovf_q, rd_valid_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, wr_idx, rd_idx;
  fb_entry_t         push_entry, head;

  always_comb begin
    lcd_off   = !lcd_on || (mode == MODE_VBL);
    swap      = lcd_off && !lcd_off_q;
    accept    = pix_wr && !lcd_off_q;
    // A pixel arriving on the swap cycle already belongs to the new frame.
    wr_bank_d = swap ? ~wr_bank_q : wr_bank_q;
    wr_idx    = swap ? '0 : wr_ptr_q;
    push      = accept && (wr_idx < PTR_END);
    push_entry = '{bank: wr_bank_d, idx: wr_idx, data: pix_data};

    rd_sel    = (!double_buffer || (wr_ptr_q >= PTR_THR)) ? wr_bank_q : ~wr_bank_q;
    rd_bank_d = rd_frame_start ? rd_sel : rd_bank_q;
    rd_idx    = rd_frame_start ? '0 : rd_ptr_q;

    // A full FIFO forces a write so it can always accept this cycle's push.
    rd_gnt    = rd_req && !fifo_full;
    pop       = !fifo_empty && !rd_gnt;

    ram_we    = pop;
    ram_wdata = pop ? head.data : '0;
    ram_addr  = '0;
    if (rd_gnt)   ram_addr = {rd_bank_d, rd_idx};
    else if (pop) ram_addr = {head.bank, head.idx};

    rd_data   = rd_valid_q ? ram_rdata : '0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lcd_off_q   <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      frame_ovf_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      lcd_off_q <= lcd_off;
      wr_bank_q <= wr_bank_d;
      if (push)      wr_ptr_q <= wr_idx + 1'b1;
      else if (swap) wr_ptr_q <= '0;
      if (accept && !push) frame_ovf_q <= 1'b1;
      rd_bank_q <= rd_bank_d;
      if (rd_gnt) rd_ptr_q <= (rd_idx == PTR_LAST) ? rd_idx : rd_idx + 1'b1;
      else        rd_ptr_q <= rd_idx;
      rd_valid_q <= rd_gnt;
    end
  end

  lcd_fb_wfifo #(
    .WIDTH($bits(fb_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_wfifo (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rd_valid  = rd_valid_q;
  assign wr_bank   = wr_bank_q;
  assign rd_bank   = rd_bank_q;
  assign frame_ovf = frame_ovf_q;

endmodule

// File: tb/tb_lcd_fb_sched.sv
// tb/tb_lcd_fb_sched.sv - directed self-checking bench for lcd_fb_sched
module tb_lcd_fb_sched;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        lcd_on, double_buffer, pix_wr, rd_frame_start, rd_req;
  logic [1:0]  mode;
  logic [14:0] pix_data, rd_data, ram_wdata, ram_rdata;
  logic        rd_gnt, rd_valid, ram_we, wr_bank, rd_bank, frame_ovf;
  logic [15:0] ram_addr;

  int total = 0;
  int bad = 0;
  int bad_idx = 0;
  logic [15:0] wa[$];
  logic [14:0] wd[$];

  lcd_fb_sched dut (
    .clk_sys(clk_sys), .reset(reset), .lcd_on(lcd_on), .mode(mode),
    .double_buffer(double_buffer), .pix_wr(pix_wr), .pix_data(pix_data),
    .rd_frame_start(rd_frame_start), .rd_req(rd_req), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .frame_ovf(frame_ovf)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM stand-in: registered read data is a fixed function of the address.
  always @(posedge clk_sys) ram_rdata <= ram_addr[14:0] ^ 15'h1234;

  always @(negedge clk_sys) begin
    if (!reset && ram_we) begin
      wa.push_back(ram_addr);
      wd.push_back(ram_wdata);
      if (ram_addr[14:0] >= 15'd23040) bad_idx++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_burst(input int n, input int d0);
    for (int i = 0; i < n; i++) begin
      pix_wr = 1'b1;
      pix_data = 15'(d0 + i);
      tick();
    end
    pix_wr = 1'b0;
    repeat (3) tick();
  endtask

  task automatic fs_pulse();
    rd_frame_start = 1'b1;
    tick();
    rd_frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; lcd_on = 1'b0; mode = 2'd0; double_buffer = 1'b0;
    pix_wr = 1'b0; pix_data = '0; rd_frame_start = 1'b0; rd_req = 1'b0;
    repeat (2) tick();
    check("rst_we", 32'(ram_we), 0);
    check("rst_gnt", 32'(rd_gnt), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_banks", 32'({wr_bank, rd_bank}), 0);
    check("rst_ovf", 32'(frame_ovf), 0);

    reset = 1'b0; lcd_on = 1'b1; mode = 2'd3;
    tick();

    // write-only
    wa.delete(); wd.delete();
    wr_burst(5, 1);
    check("wo_count", 32'(wa.size()), 5);
    for (int i = 0; i < 5 && i < wa.size(); i++) begin
      check("wo_addr", 32'(wa[i]), 32'(i));
      check("wo_data", 32'(wd[i]), 32'(i + 1));
    end
    @(negedge clk_sys);
    check("wo_empty", 32'(ram_we), 0);
    tick();

    // read priority: two entries held back by reads
    wa.delete(); wd.delete();
    pix_wr = 1'b1; pix_data = 15'd20; rd_req = 1'b1; rd_frame_start = 1'b1;
    @(negedge clk_sys);
    check("rp_fs_gnt", 32'(rd_gnt), 1);
    check("rp_fs_addr", 32'(ram_addr), 0);
    tick();
    rd_frame_start = 1'b0; pix_data = 15'd21;
    tick();
    pix_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      check("rp_gnt", 32'(rd_gnt), 1);
      check("rp_we", 32'(ram_we), 0);
      check("rp_addr", 32'(ram_addr), 32'(2 + k));
      tick();
      check("rp_valid", 32'(rd_valid), 1);
      check("rp_data", 32'(rd_data), 32'((2 + k) ^ 32'h1234));
    end
    rd_req = 1'b0;
    repeat (3) tick();
    check("rp_valid_off", 32'(rd_valid), 0);
    check("rp_drain_cnt", 32'(wa.size()), 2);
    if (wa.size() == 2) begin
      check("rp_drain_a0", 32'(wa[0]), 5);
      check("rp_drain_d0", 32'(wd[0]), 20);
      check("rp_drain_a1", 32'(wa[1]), 6);
      check("rp_drain_d1", 32'(wd[1]), 21);
    end

    // full override
    wa.delete(); wd.delete();
    for (int c = 0; c < 8; c++) begin
      pix_wr = 1'b1; pix_data = 15'(40 + c); rd_req = 1'b1;
      @(negedge clk_sys);
      check("fo_gnt", 32'(rd_gnt), (c < 4) ? 1 : 0);
      if (c >= 4) check("fo_we", 32'(ram_we), 1);
      tick();
    end
    pix_wr = 1'b0; rd_req = 1'b0;
    repeat (6) tick();
    check("fo_cnt", 32'(wa.size()), 8);
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      check("fo_addr", 32'(wa[i]), 32'(7 + i));
      check("fo_data", 32'(wd[i]), 32'(40 + i));
    end
    check("fo_ovf", 32'(frame_ovf), 0);

    // bank swap after 100 pixels
    wa.delete(); wd.delete();
    wr_burst(85, 100);
    check("bs_cnt", 32'(wa.size()), 85);
    if (wa.size() > 0) check("bs_last", 32'(wa[wa.size() - 1]), 99);
    mode = 2'd1;
    tick();
    check("bs_wr_bank", 32'(wr_bank), 1);
    wa.delete(); wd.delete();
    pix_wr = 1'b1; pix_data = 15'h7ff;
    tick();
    pix_wr = 1'b0; mode = 2'd3;
    tick();
    wr_burst(1, 32'h55);
    check("bs_new_cnt", 32'(wa.size()), 1);
    if (wa.size() == 1) begin
      check("bs_new_addr", 32'(wa[0]), 32'h8000);
      check("bs_new_data", 32'(wd[0]), 32'h55);
    end

    // read-bank selection (wr_bank=1, wr_ptr=1)
    double_buffer = 1'b0;
    fs_pulse();
    check("sel_nodb", 32'(rd_bank), 1);
    wr_burst(9598, 0);
    double_buffer = 1'b1;
    fs_pulse();
    check("sel_9599", 32'(rd_bank), 0);
    wr_burst(1, 0);
    fs_pulse();
    check("sel_9600", 32'(rd_bank), 1);

    // overflow
    wa.delete(); wd.delete();
    wr_burst(13440, 0);
    check("ov_before", 32'(frame_ovf), 0);
    if (wa.size() > 0) check("ov_last", 32'(wa[wa.size() - 1]), 32'h8000 + 23039);
    wa.delete(); wd.delete();
    wr_burst(1, 0);
    check("ov_set", 32'(frame_ovf), 1);
    check("ov_nowrite", 32'(wa.size()), 0);
    check("ov_badidx", 32'(bad_idx), 0);
    repeat (5) tick();
    check("ov_sticky", 32'(frame_ovf), 1);

    // reset with a read in flight
    rd_req = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(rd_valid), 0);
    check("ar_ovf", 32'(frame_ovf), 0);
    check("ar_banks", 32'({wr_bank, rd_bank}), 0);
    rd_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("ar_valid_rel", 32'(rd_valid), 0);
    check("ar_we", 32'(ram_we), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
